// File: rtl/aes_batch_sequencer.sv
// Batch sequencer for AES side-channel capture: runs N encryptions under one key,
// with fixed or chained plaintext, an optional gap and one scope trigger per encryption.
module aes_batch_sequencer #(
    parameter int pPT_WIDTH  = 128,
    parameter int pKEY_WIDTH = 128,
    parameter int pCNT_WIDTH = 16,
    parameter int pDLY_WIDTH = 8,
    parameter int pTIMEOUT   = 1024
) (
    input  logic                  crypto_clk,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [pKEY_WIDTH-1:0] key_i,
    input  logic [pPT_WIDTH-1:0]  text_i,
    input  logic [pCNT_WIDTH-1:0] batch_cnt_i,
    input  logic [pDLY_WIDTH-1:0] gap_dly_i,
    input  logic                  chain_i,
    output logic                  core_load_o,
    output logic [pKEY_WIDTH-1:0] core_key_o,
    output logic [pPT_WIDTH-1:0]  core_text_o,
    input  logic                  core_busy_i,
    input  logic [pPT_WIDTH-1:0]  core_text_i,
    output logic [pPT_WIDTH-1:0]  cipher_o,
    output logic [pCNT_WIDTH-1:0] enc_count_o,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic                  trigger_o
);

    localparam int TMO_W = $clog2(pTIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(pTIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_BUSY,
        S_RUN,
        S_GAP,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [pKEY_WIDTH-1:0]   key_q, key_d;
    logic [pPT_WIDTH-1:0]    text_q, text_d;
    logic [pPT_WIDTH-1:0]    cipher_q, cipher_d;
    logic [pCNT_WIDTH-1:0]   enc_count_q, enc_count_d;
    logic [pCNT_WIDTH-1:0]   target_q, target_d;
    logic [pDLY_WIDTH-1:0]   gap_val_q, gap_val_d;
    logic [pDLY_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    chain_q, chain_d;
    logic                    error_q, error_d;
    logic                    trigger_q, trigger_d;
    logic [pCNT_WIDTH-1:0]   cnt_inc;

    assign cnt_inc = enc_count_q + pCNT_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        text_d      = text_q;
        cipher_d    = cipher_q;
        enc_count_d = enc_count_q;
        target_d    = target_q;
        gap_val_d   = gap_val_q;
        gap_cnt_d   = gap_cnt_q;
        tmo_d       = tmo_q;
        chain_d     = chain_q;
        error_d     = error_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    key_d       = key_i;
                    text_d      = text_i;
                    gap_val_d   = gap_dly_i;
                    chain_d     = chain_i;
                    target_d    = (batch_cnt_i == '0) ? pCNT_WIDTH'(1) : batch_cnt_i;
                    enc_count_d = '0;
                    error_d     = 1'b0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                tmo_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else if (core_busy_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                tmo_d = tmo_q + TMO_W'(1);
                // A completion on the final budget cycle still counts as a completion.
                if (!core_busy_i) begin
                    cipher_d    = core_text_i;
                    enc_count_d = cnt_inc;
                    if (chain_q) begin
                        text_d = core_text_i;
                    end
                    if (cnt_inc == target_q) begin
                        state_d = S_DONE;
                    end else if (gap_val_q == '0) begin
                        state_d = S_LOAD;
                    end else begin
                        gap_cnt_d = gap_val_q;
                        state_d   = S_GAP;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q - pDLY_WIDTH'(1);
                if (gap_cnt_q <= pDLY_WIDTH'(1)) begin
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered from the next state so the pulse covers exactly WAIT_BUSY..RUN.
        trigger_d = (state_d == S_WAIT_BUSY) || (state_d == S_RUN);
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            text_q      <= '0;
            cipher_q    <= '0;
            enc_count_q <= '0;
            target_q    <= '0;
            gap_val_q   <= '0;
            gap_cnt_q   <= '0;
            tmo_q       <= '0;
            chain_q     <= 1'b0;
            error_q     <= 1'b0;
            trigger_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            text_q      <= text_d;
            cipher_q    <= cipher_d;
            enc_count_q <= enc_count_d;
            target_q    <= target_d;
            gap_val_q   <= gap_val_d;
            gap_cnt_q   <= gap_cnt_d;
            tmo_q       <= tmo_d;
            chain_q     <= chain_d;
            error_q     <= error_d;
            trigger_q   <= trigger_d;
        end
    end

    assign core_load_o = (state_q == S_LOAD);
    assign core_key_o  = key_q;
    assign core_text_o = text_q;
    assign cipher_o    = cipher_q;
    assign enc_count_o = enc_count_q;
    assign ready_o     = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign error_o     = error_q;
    assign trigger_o   = trigger_q;

endmodule

// File: tb/tb_aes_batch_sequencer.sv
// Self-checking bench for aes_batch_sequencer: behavioural AES core model,
// table-driven batch vectors and hand sequences for gap, ignore-start, reset and timeout.
module tb_aes_batch_sequencer;

    logic           crypto_clk = 1'b0;
    logic           reset_i;
    logic           start_i;
    logic [127:0]   key_i;
    logic [127:0]   text_i;
    logic [15:0]    batch_cnt_i;
    logic [7:0]     gap_dly_i;
    logic           chain_i;
    logic           core_load_o;
    logic [127:0]   core_key_o;
    logic [127:0]   core_text_o;
    logic           core_busy_i = 1'b0;
    logic [127:0]   core_text_i = '0;
    logic [127:0]   cipher_o;
    logic [15:0]    enc_count_o;
    logic           ready_o;
    logic           busy_o;
    logic           done_o;
    logic           error_o;
    logic           trigger_o;

    always #5 crypto_clk = ~crypto_clk;

    aes_batch_sequencer dut (
        .crypto_clk  (crypto_clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .key_i       (key_i),
        .text_i      (text_i),
        .batch_cnt_i (batch_cnt_i),
        .gap_dly_i   (gap_dly_i),
        .chain_i     (chain_i),
        .core_load_o (core_load_o),
        .core_key_o  (core_key_o),
        .core_text_o (core_text_o),
        .core_busy_i (core_busy_i),
        .core_text_i (core_text_i),
        .cipher_o    (cipher_o),
        .enc_count_o (enc_count_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .trigger_o   (trigger_o)
    );

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b};
        return t[15-n -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rcon;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
                      ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            for (int i = 0; i < 16; i++) s[i] = t[i];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] ref_ct(input logic [127:0] key, input logic [127:0] pt,
                                            input int n, input logic chain);
        logic [127:0] t, c;
        t = pt;
        c = '0;
        for (int k = 0; k < n; k++) begin
            c = aes_enc(key, t);
            if (chain) t = c;
        end
        return c;
    endfunction

    // ---------------- AES core model ----------------
    logic         core_mute = 1'b0;
    logic [3:0]   core_cnt = '0;
    logic [127:0] core_res = '0;

    always @(posedge crypto_clk) begin
        if (core_load_o && !core_mute) begin
            core_busy_i <= 1'b1;
            core_cnt    <= 4'd3;
            core_res    <= aes_enc(core_key_o, core_text_o);
        end else if (core_busy_i) begin
            if (core_cnt == 4'd0) begin
                core_busy_i <= 1'b0;
                core_text_i <= core_res;
            end else begin
                core_cnt <= core_cnt - 4'd1;
            end
        end
    end

    // ---------------- monitor ----------------
    int           n_load = 0;
    int           n_trig = 0;
    int           n_done = 0;
    logic         trig_prev = 1'b0;
    logic [127:0] act_q[$];
    logic [127:0] exp_q[$];

    always @(negedge crypto_clk) begin
        if (core_load_o) begin
            n_load <= n_load + 1;
            act_q.push_back(core_text_o);
        end
        if (trigger_o && !trig_prev) n_trig <= n_trig + 1;
        trig_prev <= trigger_o;
        if (done_o) n_done <= n_done + 1;
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_batch(input logic [127:0] key, input logic [127:0] pt,
                               input logic [15:0] batch, input logic [7:0] gap, input logic chain);
        int w;
        w = 0;
        while (!ready_o && w < 2000) begin
            @(negedge crypto_clk);
            w++;
        end
        @(negedge crypto_clk);
        key_i       = key;
        text_i      = pt;
        batch_cnt_i = batch;
        gap_dly_i   = gap;
        chain_i     = chain;
        start_i     = 1'b1;
        @(negedge crypto_clk);
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done_o && cycles < budget) begin
            @(negedge crypto_clk);
            cycles++;
        end
        chk("done_seen", done_o, 1'b1);
    endtask

    task automatic wait_cond_cnt(input logic [15:0] cnt, input int budget);
        int w;
        w = 0;
        while (!(enc_count_o == cnt && trigger_o) && w < budget) begin
            @(negedge crypto_clk);
            w++;
        end
        chk("wait_batch_running", (enc_count_o == cnt) && trigger_o, 1'b1);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [15:0]  batch;
        logic [7:0]   gap;
        logic         chain;
        int           exp_n;
        logic [127:0] exp_ct;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        int           l0, t0, d0, cyc;
        logic [127:0] t;
        exp_q.delete();
        act_q.delete();
        t = v.pt;
        for (int k = 0; k < v.exp_n; k++) begin
            exp_q.push_back(t);
            if (v.chain) t = aes_enc(v.key, t);
        end
        l0 = n_load;
        t0 = n_trig;
        d0 = n_done;
        start_batch(v.key, v.pt, v.batch, v.gap, v.chain);
        chk("load_latency", core_load_o, 1'b1);
        chk("load_key", core_key_o, v.key);
        chk("error_cleared", error_o, 1'b0);
        wait_done(4000, cyc);
        chk("enc_count", enc_count_o, 128'(v.exp_n));
        chk("error", error_o, 1'b0);
        chk("cipher", cipher_o, v.exp_ct);
        @(negedge crypto_clk);
        chk("done_one_cycle", done_o, 1'b0);
        chk("ready_after", ready_o, 1'b1);
        chk("load_pulses", 128'(n_load - l0), 128'(v.exp_n));
        chk("trigger_pulses", 128'(n_trig - t0), 128'(v.exp_n));
        chk("done_pulses", 128'(n_done - d0), 128'd1);
        while (exp_q.size() > 0) begin
            if (act_q.size() == 0) begin
                chk("load_text_missing", 128'd0, exp_q.pop_front());
            end else begin
                chk("load_text", act_q.pop_front(), exp_q.pop_front());
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        int l0, t0, d0, cyc, w;

        reset_i     = 1'b1;
        start_i     = 1'b0;
        key_i       = '0;
        text_i      = '0;
        batch_cnt_i = '0;
        gap_dly_i   = '0;
        chain_i     = 1'b0;
        build_sbox();

        vecs[0] = '{key: K1, pt: P1, batch: 16'd1, gap: 8'd0, chain: 1'b0, exp_n: 1, exp_ct: C1};
        vecs[1] = '{key: K1, pt: P1, batch: 16'd3, gap: 8'd0, chain: 1'b1, exp_n: 3,
                    exp_ct: ref_ct(K1, P1, 3, 1'b1)};
        vecs[2] = '{key: K1, pt: P1, batch: 16'd0, gap: 8'd0, chain: 1'b0, exp_n: 1, exp_ct: C1};
        vecs[3] = '{key: K2, pt: P2, batch: 16'd2, gap: 8'd3, chain: 1'b0, exp_n: 2, exp_ct: C2};
        vecs[4] = '{key: K2, pt: P1, batch: 16'd4, gap: 8'd1, chain: 1'b1, exp_n: 4,
                    exp_ct: ref_ct(K2, P1, 4, 1'b1)};

        // Reset state
        repeat (3) @(negedge crypto_clk);
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_error", error_o, 1'b0);
        chk("rst_trigger", trigger_o, 1'b0);
        chk("rst_load", core_load_o, 1'b0);
        chk("rst_count", enc_count_o, 128'd0);
        chk("rst_cipher", cipher_o, 128'd0);
        reset_i = 1'b0;
        @(negedge crypto_clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Gap of 5: exactly five quiet cycles between the RUN exit and the second load
        start_batch(K1, P1, 16'd2, 8'd5, 1'b0);
        w = 0;
        while (enc_count_o != 16'd1 && w < 2000) begin
            @(negedge crypto_clk);
            w++;
        end
        chk("gap_first_done", enc_count_o, 128'd1);
        for (int k = 0; k < 5; k++) begin
            chk("gap_trigger_low", trigger_o, 1'b0);
            chk("gap_no_load", core_load_o, 1'b0);
            @(negedge crypto_clk);
        end
        chk("gap_len_load", core_load_o, 1'b1);
        wait_done(2000, cyc);
        chk("gap_count", enc_count_o, 128'd2);
        chk("gap_cipher", cipher_o, C1);
        @(negedge crypto_clk);

        // Start while running is ignored
        l0 = n_load;
        start_batch(K1, P1, 16'd2, 8'd0, 1'b1);
        wait_cond_cnt(16'd0, 2000);
        text_i  = P2;
        start_i = 1'b1;
        @(negedge crypto_clk);
        start_i = 1'b0;
        wait_done(2000, cyc);
        chk("ign_count", enc_count_o, 128'd2);
        chk("ign_cipher", cipher_o, ref_ct(K1, P1, 2, 1'b1));
        @(negedge crypto_clk);
        chk("ign_loads", 128'(n_load - l0), 128'd2);

        // Reset during the second of four encryptions, with start asserted alongside
        start_batch(K1, P1, 16'd4, 8'd0, 1'b0);
        wait_cond_cnt(16'd1, 2000);
        reset_i = 1'b1;
        start_i = 1'b1;
        @(negedge crypto_clk);
        chk("mid_rst_ready", ready_o, 1'b1);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_count", enc_count_o, 128'd0);
        chk("mid_rst_trigger", trigger_o, 1'b0);
        chk("mid_rst_load", core_load_o, 1'b0);
        chk("mid_rst_cipher", cipher_o, 128'd0);
        reset_i = 1'b0;
        start_i = 1'b0;
        @(negedge crypto_clk);
        chk("post_rst_idle", ready_o, 1'b1);
        repeat (10) @(negedge crypto_clk);

        // Timeout: the core never goes busy
        core_mute = 1'b1;
        l0 = n_load;
        t0 = n_trig;
        d0 = n_done;
        start_batch(K1, P1, 16'd3, 8'd0, 1'b0);
        chk("tmo_load", core_load_o, 1'b1);
        wait_done(3000, cyc);
        chk("tmo_cycles", 128'(cyc), 128'd1025);
        chk("tmo_error", error_o, 1'b1);
        chk("tmo_count", enc_count_o, 128'd0);
        chk("tmo_cipher", cipher_o, 128'd0);
        chk("tmo_trigger_in_done", trigger_o, 1'b0);
        @(negedge crypto_clk);
        chk("tmo_error_sticky", error_o, 1'b1);
        chk("tmo_loads", 128'(n_load - l0), 128'd1);
        chk("tmo_triggers", 128'(n_trig - t0), 128'd1);
        chk("tmo_dones", 128'(n_done - d0), 128'd1);
        core_mute = 1'b0;

        // The next start clears the error and runs normally
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
